// File: rtl/div_pkg.sv
// div_pkg
//   Shared constants and types for the sequential MIPS DIV/DIVU unit.
//   DIV_WIDTH : operand width (quotient and remainder are each this wide)
//   DIV_ITERS : restoring iterations per division (one quotient bit each)
//   DIV_CNT_W : width of the iteration counter
//   div_state_e : sequencer states
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step
//   One combinational restoring-division iteration on magnitudes.
//   i_rem  : partial remainder (WIDTH+1 bits, always < divisor on entry)
//   i_bit  : next dividend bit, shifted in at the LSB
//   i_dvs  : divisor magnitude
//   o_rem  : updated partial remainder
//   o_qbit : quotient bit (inverted borrow of the trial subtraction)
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_diff;

    assign w_shift = {i_rem, i_bit};
    // The shifted value is below 2*divisor, so the difference lies in
    // (-2^WIDTH, 2^(WIDTH+1)) and its top bit is exactly the borrow.
    assign w_diff  = w_shift - {2'b00, i_dvs};
    assign o_qbit  = ~w_diff[WIDTH+1];
    assign o_rem   = o_qbit ? w_diff[WIDTH:0] : w_shift[WIDTH:0];

endmodule

// File: rtl/div_seq.sv
// div_seq
//   Multi-cycle DIV/DIVU sequencer beside the execute-stage ALU.
//   Accepts operands in IDLE, converts to magnitudes in PREP, runs one
//   restoring step per cycle in RUN, applies sign fix-up on entry to DONE.
//   Ports:
//     clk, rst      : clock, asynchronous active-high reset
//     start         : division request (sampled in IDLE only)
//     signed_div    : 1 = DIV, 0 = DIVU (sampled with start)
//     a, b          : dividend, divisor (sampled with start)
//     annul         : execute flush; cancels in-flight or same-cycle request
//     stall_o       : stall request to the hazard unit
//     ready         : one-cycle pulse, result valid
//     result        : {remainder, quotient} for HI/LO
//   Build option: DIV_EARLY_TERM_EN - finish in PREP when |a| < |b|.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               annul,
    output logic               stall_o,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e         r_state;
    div_state_e         w_state_nxt;

    // r_dvd/r_dvs hold the raw operands during PREP, magnitudes during RUN.
    logic [WIDTH-1:0]   r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic               r_sgn;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_result;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div0;
    logic               w_early;
    logic [WIDTH:0]     w_step_rem;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_q_raw;
    logic [WIDTH-1:0]   w_r_raw;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Magnitudes; the most negative value maps to itself, which is the
    // correct unsigned magnitude, so MIN / -1 needs no special case.
    assign w_a_neg = r_sgn & r_dvd[WIDTH-1];
    assign w_b_neg = r_sgn & r_dvs[WIDTH-1];
    assign w_a_mag = w_a_neg ? -r_dvd : r_dvd;
    assign w_b_mag = w_b_neg ? -r_dvs : r_dvs;
    assign w_div0  = (r_dvs == '0);

`ifdef DIV_EARLY_TERM_EN
    assign w_early = ~w_div0 & (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_dvd[WIDTH-1]),
        .i_dvs  (r_dvs),
        .o_rem  (w_step_rem),
        .o_qbit (w_qbit)
    );

    assign w_q_raw = {r_quo[WIDTH-2:0], w_qbit};
    assign w_r_raw = w_step_rem[WIDTH-1:0];
    assign w_q_fix = r_neg_q ? -w_q_raw : w_q_raw;
    assign w_r_fix = r_neg_r ? -w_r_raw : w_r_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        stall_o     = 1'b0;
        ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !annul) begin
                    w_state_nxt = S_PREP;
                    stall_o     = 1'b1;
                end
            end
            S_PREP: begin
                stall_o     = 1'b1;
                w_state_nxt = (w_div0 || w_early) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                stall_o = 1'b1;
                if (r_cnt == '0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                ready       = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Flush wins over every other transition.
        if (annul && r_state != S_IDLE) w_state_nxt = S_IDLE;
    end

    // Datapath. result is written only when the next state is DONE, so an
    // annulled operation never disturbs the previously delivered value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_sgn    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !annul) begin
                        r_dvd <= a;
                        r_dvs <= b;
                        r_sgn <= signed_div;
                    end
                end
                S_PREP: begin
                    r_dvd   <= w_a_mag;
                    r_dvs   <= w_b_mag;
                    r_neg_q <= w_a_neg ^ w_b_neg;
                    r_neg_r <= w_a_neg;
                    r_rem   <= '0;
                    r_quo   <= '0;
                    r_cnt   <= CNT_W'(WIDTH - 1);
                    // Short paths report the raw dividend as remainder.
                    if (w_state_nxt == S_DONE) begin
                        if (w_div0) r_result <= {r_dvd, {WIDTH{1'b1}}};
                        else        r_result <= {r_dvd, {WIDTH{1'b0}}};
                    end
                end
                S_RUN: begin
                    r_rem <= w_step_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
                    r_quo <= w_q_raw;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_state_nxt == S_DONE) r_result <= {w_r_fix, w_q_fix};
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall_o;
    logic        ready;
    logic [63:0] result;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam int LAT_SMALL = 2;
`else
    localparam int LAT_SMALL = 34;
`endif

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .annul      (annul),
        .stall_o    (stall_o),
        .ready      (ready),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch cycles T+1.. for ready; stall_o must be
    // high exactly for cycles before the expected ready cycle.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] da,
                           input logic [31:0] db, input int exp_lat, input logic [63:0] exp_res);
        int   lat;
        logic stall_bad;
        @(posedge clk); #1;
        start = 1'b1; signed_div = sg; a = da; b = db;
        @(negedge clk);
        check({tag, "_stall_T"}, 64'(stall_o), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        stall_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall_o !== (k < exp_lat)) stall_bad = 1'b1;
            if (ready === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_lat"},    64'(lat), 64'(exp_lat));
        check({tag, "_stall"},  64'(stall_bad), 64'd0);
        check({tag, "_result"}, result, exp_res);
    endtask

    initial begin
        logic       bad;
        logic [6:0] rv;

        rst = 1'b1; start = 1'b0; signed_div = 1'b0; a = '0; b = '0; annul = 1'b0;
        #12;
        check("rst_stall",  64'(stall_o), 64'd0);
        check("rst_ready",  64'(ready),   64'd0);
        check("rst_result", result,       64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        run_div("divu_100_7",  1'b0, 32'd100,       32'd7,          34, {32'd2, 32'd14});
        run_div("div_m7_2",    1'b1, 32'hFFFF_FFF9, 32'd2,          34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_div("div_min_m1",  1'b1, 32'h8000_0000, 32'hFFFF_FFFF,  34, {32'd0, 32'h8000_0000});
        run_div("divu_by0",    1'b0, 32'h0000_1234, 32'd0,          2,  {32'h0000_1234, 32'hFFFF_FFFF});

        // annul at T+10 of DIVU 50/5
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd50; b = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("annul_pre_stall", 64'(stall_o), 64'd1);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_stall",  64'(stall_o), 64'd0);
        check("annul_ready",  64'(ready),   64'd0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
        end
        check("annul_quiet",  64'(bad), 64'd0);
        check("annul_result", result, {32'h0000_1234, 32'hFFFF_FFFF});

        run_div("div_7_m2",    1'b1, 32'd7,         32'hFFFF_FFFE,  34, {32'd1, 32'hFFFF_FFFD});
        run_div("div_m5_by0",  1'b1, 32'hFFFF_FFFB, 32'd0,          2,  {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        run_div("divu_5_9",    1'b0, 32'd5,         32'd9,   LAT_SMALL, {32'd5, 32'd0});
        run_div("divu_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,          34, {32'd0, 32'hFFFF_FFFF});
        run_div("divu_max_max",1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  34, {32'd0, 32'd1});

        // start together with annul in IDLE is dropped
        @(posedge clk); #1;
        start = 1'b1; annul = 1'b1; signed_div = 1'b0; a = 32'd3; b = 32'd1;
        @(negedge clk);
        check("sa_stall", 64'(stall_o), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
        end
        check("sa_quiet",  64'(bad), 64'd0);
        check("sa_result", result, {32'd0, 32'd1});

        // start held high: ignored in DONE, re-accepted in the following IDLE
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd9; b = 32'd0;
        @(negedge clk);
        rv = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rv[k] = ready;
        end
        check("b2b_ready_pattern", 64'(rv), 64'(7'b0100100));
        check("b2b_result", result, {32'd9, 32'hFFFF_FFFF});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);

        // asynchronous reset in the middle of RUN
        @(posedge clk); #1;
        start = 1'b1; signed_div = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_stall",  64'(stall_o), 64'd0);
        check("arst_ready",  64'(ready),   64'd0);
        check("arst_result", result,       64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ready !== 1'b0 || stall_o !== 1'b0) bad = 1'b1;
        end
        check("arst_quiet", 64'(bad), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for MIPS DIV/DIVU. It takes operands from the execute stage and runs a 32-iteration restoring division. It holds the pipeline stall line toward the hazard unit while busy and presents a 64-bit {remainder, quotient} word for the HI/LO write path. It replaces single-cycle division inside the ALU and sits beside the ALU in the execute stage.

## Interface
Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request a division; sampled only in IDLE
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
- a  in  WIDTH  dividend; sampled with start
- b  in  WIDTH  divisor; sampled with start
- annul  in  1  cancel any in-flight or same-cycle request (execute flush)
- stall_o  out  1  stall request to the hazard unit
- ready  out  1  one-cycle pulse; result is valid
- result  out  2*WIDTH  {remainder[63:32], quotient[31:0]}, i.e. hi/lo order

## Operation
- States:
  - IDLE: waits for a request.
  - PREP: latches absolute values and signs, loads the counter with WIDTH-1.
  - RUN: one restoring step per cycle, counter decrements.
  - DONE: applies sign fix-up and pulses ready.
- Transitions:
  - IDLE→PREP on start & ~annul.
  - PREP→RUN normally.
  - PREP→DONE on divide-by-zero, or on the early-termination case (see Configuration).
  - RUN→DONE when the counter is 0 at the end of the step.
  - DONE→IDLE always.
  - Any non-IDLE state → IDLE on annul, taking priority over all other transitions.
- stall_o = (state ∈ {PREP, RUN}) | (state==IDLE & start & ~annul). It is low in DONE, so the instruction advances in the same cycle ready is high.
- Signed mode:
  - Operands are converted to magnitude. The quotient is negated if sign(a)^sign(b). The remainder takes the sign of a.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 with no special casing.
- Restoring step: partial remainder is WIDTH+1 bits. It is shifted left with the next dividend bit, trial-subtracted by |b|, and the quotient bit is the inverted borrow.
- Divide by zero (b==0): quotient = all ones, remainder = a, in both modes.
- result is loaded only on entry to DONE. It holds its value until the next DONE; annul does not alter it.
- start while not IDLE is ignored.
- annul in the same cycle as start in IDLE: the request is not accepted and stall_o stays 0.

## Timing
- Reset values: state IDLE, stall_o 0, ready 0, result 0, counter 0.
- Request accepted at edge T (IDLE, start=1).
- PREP occupies cycle T+1.
- RUN occupies cycles T+2..T+33 (32 steps).
- DONE is cycle T+34, with ready=1; IDLE is entered at T+35.
- Full latency: 34 cycles from acceptance to ready. stall_o is high for cycles T..T+33.
- Divide by zero: DONE at T+2.
- A back-to-back start is accepted at T+35 at the earliest. start presented during DONE is ignored.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at reset values. No ready pulse follows.
- annul observed in cycle k: state is IDLE at k+1, stall_o drops at k+1, and no ready pulse follows.

## Configuration
- DIV_EARLY_TERM_EN defined:
  - In PREP, if |a| < |b| (and b≠0), go directly to DONE with quotient 0 and remainder a.
  - Latency is then 2 cycles (ready at T+2).
- DIV_EARLY_TERM_EN undefined: every nonzero divisor takes the full 32 RUN cycles.

## Structure
- Shared package div_pkg:
  - State enumeration (IDLE, PREP, RUN, DONE).
  - DIV_WIDTH=32.
  - DIV_ITERS=32.
  - Counter width constant.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once in RUN.

## Test plan
- DIVU a=100, b=7 → ready at T+34, result = {32'd2, 32'd14}; stall_o high T..T+33 exactly.
- DIV a=-7 (0xFFFFFFF9), b=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → quotient 0x80000000, remainder 0.
- DIVU a=0x1234, b=0 → ready at T+2, result = {0x00001234, 0xFFFFFFFF}.
- annul asserted at T+10 during a DIVU 50/5 → IDLE and stall_o=0 at T+11, no ready, result unchanged.
- DIVU a=5, b=9:
  - With DIV_EARLY_TERM_EN: ready at T+2, result {5, 0}.
  - Without it: ready at T+34, same result.
